// File: rtl/acc_pkg.sv
// Shared definitions for the matrix-multiply engine.
//   - header word field positions (M, N, K)
//   - int8 lane geometry, accumulator and partial-sum widths
//   - controller state encoding
//   - mask_pad(): zeroes the byte lanes of a word that lie at or beyond K
package acc_pkg;

  localparam int LANES     = 8;
  localparam int LANE_W    = 8;
  localparam int WORD_W    = LANES * LANE_W;
  localparam int ACC_W     = 32;
  localparam int PSUM_W    = 20;

  localparam int HDR_M_LSB = 0;
  localparam int HDR_N_LSB = 16;
  localparam int HDR_K_LSB = 32;
  localparam int HDR_FLD_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD_A,
    S_DOT,
    S_WR,
    S_DONE
  } state_t;

  // word: index of this word within its row; k: row length in elements.
  function automatic logic [WORD_W-1:0] mask_pad(input logic [WORD_W-1:0] d,
                                                 input logic [15:0]       word,
                                                 input logic [15:0]       k);
    logic [WORD_W-1:0] r;
    r = d;
    for (int l = 0; l < LANES; l++) begin
      if ((int'(word) * LANES + l) >= int'(k)) r[l*LANE_W +: LANE_W] = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/acc_if.sv
// Bus bundle between the engine, the input RAM read port and the result RAM write port.
//   comp_enb      start request
//   mem_addr      input RAM address        mem_data      input RAM q
//   mem_read_enb  input RAM read enable    mem_write_enb result RAM write strobe
//   res_addr      result RAM address       res_data      result RAM write data
//   busyb         active-low busy          done          completion flag
// master = engine side, slave = environment (RAMs / host) side.
interface acc_if #(
  parameter int IDW = 64,
  parameter int IAW = 23,
  parameter int RDW = 64,
  parameter int RAW = 23
);
  logic           comp_enb;
  logic [IAW-1:0] mem_addr;
  logic [IDW-1:0] mem_data;
  logic           mem_read_enb;
  logic           mem_write_enb;
  logic [RAW-1:0] res_addr;
  logic [RDW-1:0] res_data;
  logic           busyb;
  logic           done;

  modport master (
    input  comp_enb, mem_data,
    output mem_addr, mem_read_enb, mem_write_enb, res_addr, res_data, busyb, done
  );

  modport slave (
    output comp_enb, mem_data,
    input  mem_addr, mem_read_enb, mem_write_enb, res_addr, res_data, busyb, done
  );
endinterface

// File: rtl/mac8.sv
// Eight signed int8 x int8 products summed by an adder tree (combinational).
//   i_a, i_b  eight int8 lanes each, lane l in bits 8l+7:8l
//   o_sum     signed sum of the eight products
module mac8
  import acc_pkg::*;
(
  input  logic        [WORD_W-1:0] i_a,
  input  logic        [WORD_W-1:0] i_b,
  output logic signed [PSUM_W-1:0] o_sum
);
  logic signed [15:0] w_prod [LANES];
  logic signed [16:0] w_s1   [4];
  logic signed [17:0] w_s2   [2];
  logic signed [18:0] w_s3;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_prod[l] = 16'($signed(i_a[l*LANE_W +: LANE_W])) *
                  16'($signed(i_b[l*LANE_W +: LANE_W]));
    end
    for (int n = 0; n < 4; n++) w_s1[n] = 17'(w_prod[2*n]) + 17'(w_prod[2*n+1]);
    for (int n = 0; n < 2; n++) w_s2[n] = 18'(w_s1[2*n]) + 18'(w_s1[2*n+1]);
    w_s3  = 19'(w_s2[0]) + 19'(w_s2[1]);
    o_sum = PSUM_W'(w_s3);
  end
endmodule

// File: rtl/ram.sv
// Generic single-port synchronous RAM.
//   clk      clock
//   web      1 = write d, 0 = read into q (only while cs)
//   address  word address
//   d        write data
//   q        read data, registered
//   cs       chip select
// Contents are not reset.
module ram #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 23
) (
  input  logic                  clk,
  input  logic                  web,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q,
  input  logic                  cs
);
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (cs) begin
      if (web) r_mem[address] <= d;
      else     q <= r_mem[address];
    end
  end
endmodule

// File: rtl/accelerator_core.sv
// Integer matrix-multiply engine: C = A * B from a header plus int8 A (MxK) and
// B^T (NxK) held in the input RAM; each C[i][j] goes out as one sign-extended
// 64-bit word at result address i*N+j.
//   clk, rst_n  clock, async active-low reset
//   bus         acc_if master: input RAM read port, result RAM write port,
//               comp_enb start pulse, busyb / done status
//
// state  | meaning
// IDLE   | waiting for comp_enb, busyb=1
// HDR    | read word 0, latch and validate M/N/K
// LOAD_A | stream A row i into the row buffer
// DOT    | stream B^T row j, accumulate against the buffer
// WR     | write C[i][j]
// DONE   | raise done, drop busy
module accelerator_core
  import acc_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH  = 64,
  parameter int INPUT_ADDR_WIDTH  = 23,
  parameter int RESULT_DATA_WIDTH = 64,
  parameter int RESULT_ADDR_WIDTH = 23,
  parameter int MAC_SIZE          = 128,
  parameter int BIG_MAC_SIZE      = 512
) (
  input logic   clk,
  input logic   rst_n,
  acc_if.master bus
);
  localparam int IAW    = INPUT_ADDR_WIDTH;
  localparam int RAW    = RESULT_ADDR_WIDTH;
  localparam int RDW    = RESULT_DATA_WIDTH;
  localparam int MN_W   = $clog2(MAC_SIZE + 1);
  localparam int K_W    = $clog2(BIG_MAC_SIZE + 1);
  localparam int BUF_D  = BIG_MAC_SIZE / LANES;
  localparam int BUF_AW = $clog2(BUF_D);
  localparam int W_W    = BUF_AW + 1;

  state_t                r_state, w_next;
  logic [W_W-1:0]        r_issue_left, r_rx_idx, r_w;
  logic [IAW-1:0]        r_rd_addr, r_a_row, r_b_row, r_b_base;
  logic                  r_rd_vld;
  logic [MN_W-1:0]       r_m, r_n, r_i, r_j;
  logic [K_W-1:0]        r_k;
  logic [ACC_W-1:0]      r_acc;
  logic [RAW-1:0]        r_res_addr;
  logic [RDW-1:0]        r_res_data;
  logic                  r_busyb, r_done;
  logic [INPUT_DATA_WIDTH-1:0] r_abuf [BUF_D];

  logic [HDR_FLD_W-1:0]  w_hdr_m, w_hdr_n, w_hdr_k;
  logic [W_W-1:0]        w_hdr_w;
  logic [IAW-1:0]        w_b_base;
  logic                  w_hdr_ok, w_rd_en, w_last_rx, w_row_end, w_mat_end;
  logic [WORD_W-1:0]     w_a_word, w_b_word, w_rx_masked;
  logic signed [PSUM_W-1:0] w_psum;
  logic [ACC_W-1:0]      w_acc_next;

  assign w_hdr_m  = bus.mem_data[HDR_M_LSB +: HDR_FLD_W];
  assign w_hdr_n  = bus.mem_data[HDR_N_LSB +: HDR_FLD_W];
  assign w_hdr_k  = bus.mem_data[HDR_K_LSB +: HDR_FLD_W];
  assign w_hdr_w  = W_W'((w_hdr_k + 16'd7) >> 3);
  assign w_b_base = IAW'(1) + IAW'(w_hdr_m) * IAW'(w_hdr_w);
  assign w_hdr_ok = (w_hdr_m != '0) && (w_hdr_n != '0) && (w_hdr_k != '0) &&
                    (w_hdr_m <= 16'(MAC_SIZE)) && (w_hdr_n <= 16'(MAC_SIZE)) &&
                    (w_hdr_k <= 16'(BIG_MAC_SIZE));

  // Reads are issued while words remain; data returns one cycle later (r_rd_vld).
  assign w_rd_en   = ((r_state == S_HDR) || (r_state == S_LOAD_A) || (r_state == S_DOT)) &&
                     (r_issue_left != '0);
  assign w_last_rx = r_rd_vld && (r_rx_idx == r_w - W_W'(1));
  assign w_row_end = (r_j == r_n - MN_W'(1));
  assign w_mat_end = (r_i == r_m - MN_W'(1));

  assign w_rx_masked = mask_pad(bus.mem_data, 16'(r_rx_idx), 16'(r_k));
  assign w_a_word    = r_abuf[r_rx_idx[BUF_AW-1:0]];
  assign w_b_word    = w_rx_masked;

  mac8 u_mac8 (
    .i_a   (w_a_word),
    .i_b   (w_b_word),
    .o_sum (w_psum)
  );

  assign w_acc_next = r_acc + ACC_W'(w_psum);

  assign bus.mem_addr      = r_rd_addr;
  assign bus.mem_read_enb  = w_rd_en;
  assign bus.mem_write_enb = (r_state == S_WR);
  assign bus.res_addr      = r_res_addr;
  assign bus.res_data      = r_res_data;
  assign bus.busyb         = r_busyb;
  assign bus.done          = r_done;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.comp_enb) w_next = S_HDR;
      S_HDR:    if (r_rd_vld) w_next = w_hdr_ok ? S_LOAD_A : S_DONE;
      S_LOAD_A: if (w_last_rx) w_next = S_DOT;
      S_DOT:    if (w_last_rx) w_next = S_WR;
      S_WR: begin
        if (!w_row_end)      w_next = S_DOT;
        else if (!w_mat_end) w_next = S_LOAD_A;
        else                 w_next = S_DONE;
      end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Row buffer holds no control state, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD_A && r_rd_vld) r_abuf[r_rx_idx[BUF_AW-1:0]] <= w_rx_masked;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_left <= '0;
      r_rx_idx     <= '0;
      r_w          <= '0;
      r_rd_addr    <= '0;
      r_a_row      <= '0;
      r_b_row      <= '0;
      r_b_base     <= '0;
      r_rd_vld     <= 1'b0;
      r_m          <= '0;
      r_n          <= '0;
      r_i          <= '0;
      r_j          <= '0;
      r_k          <= '0;
      r_acc        <= '0;
      r_res_addr   <= '0;
      r_res_data   <= '0;
      r_busyb      <= 1'b1;
      r_done       <= 1'b0;
    end else begin
      r_rd_vld <= w_rd_en;
      if (w_rd_en) begin
        r_rd_addr    <= r_rd_addr + IAW'(1);
        r_issue_left <= r_issue_left - W_W'(1);
      end
      if (r_rd_vld) r_rx_idx <= r_rx_idx + W_W'(1);

      case (r_state)
        S_IDLE: if (bus.comp_enb) begin
          r_done       <= 1'b0;
          r_busyb      <= 1'b0;
          r_rd_addr    <= '0;
          r_issue_left <= W_W'(1);
          r_rx_idx     <= '0;
        end
        S_HDR: if (r_rd_vld) begin
          r_m          <= MN_W'(w_hdr_m);
          r_n          <= MN_W'(w_hdr_n);
          r_k          <= K_W'(w_hdr_k);
          r_w          <= w_hdr_w;
          r_b_base     <= w_b_base;
          r_a_row      <= IAW'(1);
          r_rd_addr    <= IAW'(1);
          r_issue_left <= w_hdr_w;
          r_rx_idx     <= '0;
          r_i          <= '0;
          r_j          <= '0;
          r_res_addr   <= '0;
        end
        S_LOAD_A: if (w_last_rx) begin
          r_b_row      <= r_b_base;
          r_rd_addr    <= r_b_base;
          r_issue_left <= r_w;
          r_rx_idx     <= '0;
          r_acc        <= '0;
        end
        S_DOT: if (r_rd_vld) begin
          r_acc <= w_acc_next;
          if (w_last_rx) begin
            r_res_data <= RDW'($signed(w_acc_next));
            r_rx_idx   <= '0;
          end
        end
        S_WR: begin
          r_res_addr <= r_res_addr + RAW'(1);
          if (!w_row_end) begin
            r_j          <= r_j + MN_W'(1);
            r_b_row      <= r_b_row + IAW'(r_w);
            r_rd_addr    <= r_b_row + IAW'(r_w);
            r_issue_left <= r_w;
            r_rx_idx     <= '0;
            r_acc        <= '0;
          end else if (!w_mat_end) begin
            r_i          <= r_i + MN_W'(1);
            r_j          <= '0;
            r_a_row      <= r_a_row + IAW'(r_w);
            r_rd_addr    <= r_a_row + IAW'(r_w);
            r_issue_left <= r_w;
            r_rx_idx     <= '0;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busyb <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_accelerator_core.sv
module tb_accelerator_core;
  typedef struct packed {
    logic [22:0] addr;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tb_ld = 1'b0;
  logic [13:0] tb_ld_addr = '0;
  logic [63:0] tb_ld_data = '0;
  logic        tb_rd = 1'b0;
  logic [13:0] tb_rd_addr = '0;
  logic [63:0] w_res_q;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int wr_cnt   = 0;
  exp_t exp_q[$];

  int ta  [128][512];
  int tbm [128][512];

  always #5 clk = ~clk;

  acc_if #(.IDW(64), .IAW(23), .RDW(64), .RAW(23)) bus ();

  accelerator_core u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  ram #(.DATA_WIDTH(64), .ADDR_WIDTH(14)) u_in_ram (
    .clk     (clk),
    .web     (tb_ld),
    .address (tb_ld ? tb_ld_addr : bus.mem_addr[13:0]),
    .d       (tb_ld_data),
    .q       (bus.mem_data),
    .cs      (tb_ld | bus.mem_read_enb)
  );

  ram #(.DATA_WIDTH(64), .ADDR_WIDTH(14)) u_res_ram (
    .clk     (clk),
    .web     (bus.mem_write_enb),
    .address (tb_rd ? tb_rd_addr : bus.res_addr[13:0]),
    .d       (bus.res_data),
    .q       (w_res_q),
    .cs      (tb_rd | bus.mem_write_enb)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    chk_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got 0x%h want 0x%h", name, got, want);
  endtask

  // Compare process: every result write must match the head of the model queue.
  always @(negedge clk) begin
    exp_t e;
    if (bus.mem_read_enb) begin
      chk_cnt++;
      if (!bus.mem_write_enb && bus.mem_addr < 23'd16384) pass_cnt++;
      else $display("FAIL read_cycle: addr=%0d wr=%b", bus.mem_addr, bus.mem_write_enb);
    end
    if (bus.mem_write_enb) begin
      wr_cnt++;
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: addr=%0d data=0x%h", bus.res_addr, bus.res_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.res_addr == e.addr && bus.res_data == e.data && !bus.mem_read_enb) pass_cnt++;
        else $display("FAIL result_write: got addr=%0d data=0x%h rd=%b want addr=%0d data=0x%h",
                      bus.res_addr, bus.res_data, bus.mem_read_enb, e.addr, e.data);
      end
    end
  end

  task automatic wr_in(input int addr, input logic [63:0] data);
    tb_ld      = 1'b1;
    tb_ld_addr = 14'(addr);
    tb_ld_data = data;
    @(negedge clk);
    tb_ld      = 1'b0;
  endtask

  task automatic read_res(input int addr, output logic [63:0] q);
    @(negedge clk);
    tb_rd      = 1'b1;
    tb_rd_addr = 14'(addr);
    @(negedge clk);
    q     = w_res_q;
    tb_rd = 1'b0;
  endtask

  function automatic logic [63:0] pack_word(input bit is_a, input int row, input int wi,
                                            input int k, input bit garbage);
    logic [63:0] word;
    int kk;
    word = '0;
    for (int l = 0; l < 8; l++) begin
      kk = wi * 8 + l;
      if (kk < k) word[l*8 +: 8] = is_a ? 8'(ta[row][kk]) : 8'(tbm[row][kk]);
      else if (garbage) word[l*8 +: 8] = 8'(8'h81 + l * 29 + row * 3 + (is_a ? 0 : 7));
    end
    return word;
  endfunction

  // Writes the job into the input RAM and queues the expected C in row-major order.
  task automatic load_job(input int m, input int n, input int k, input bit garbage);
    int w;
    int c;
    exp_t e;
    w = (k + 7) / 8;
    @(negedge clk);
    wr_in(0, {16'h0, 16'(k), 16'(n), 16'(m)});
    if (m >= 1 && m <= 128 && n >= 1 && n <= 128 && k >= 1 && k <= 512) begin
      for (int i = 0; i < m; i++)
        for (int wi = 0; wi < w; wi++) wr_in(1 + i * w + wi, pack_word(1'b1, i, wi, k, garbage));
      for (int j = 0; j < n; j++)
        for (int wi = 0; wi < w; wi++) wr_in(1 + m * w + j * w + wi, pack_word(1'b0, j, wi, k, garbage));
      for (int i = 0; i < m; i++) begin
        for (int j = 0; j < n; j++) begin
          c = 0;
          for (int kk = 0; kk < k; kk++) c += ta[i][kk] * tbm[j][kk];
          e.addr = 23'(i * n + j);
          e.data = 64'(longint'(c));
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic start_job(input string tag);
    @(negedge clk);
    bus.comp_enb = 1'b1;
    @(negedge clk);
    bus.comp_enb = 1'b0;
    check({tag, "_done_cleared"}, {63'b0, bus.done}, 64'd0);
    check({tag, "_busy"}, {63'b0, bus.busyb}, 64'd0);
  endtask

  task automatic wait_done(input string tag);
    int c;
    c = 0;
    while (!bus.done && c < 20000) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_done"}, {63'b0, bus.done}, 64'd1);
    check({tag, "_idle"}, {63'b0, bus.busyb}, 64'd1);
  endtask

  task automatic run_job(input int m, input int n, input int k, input bit garbage, input string tag);
    int w0;
    bit valid;
    valid = (m >= 1 && m <= 128 && n >= 1 && n <= 128 && k >= 1 && k <= 512);
    load_job(m, n, k, garbage);
    w0 = wr_cnt;
    start_job(tag);
    wait_done(tag);
    check({tag, "_writes"}, 64'(wr_cnt - w0), valid ? 64'(m * n) : 64'd0);
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [63:0] q;
    int w0, c;
    bit rd_seen;
    bus.comp_enb = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_busyb", {63'b0, bus.busyb}, 64'd1);
    check("rst_done", {63'b0, bus.done}, 64'd0);
    check("rst_rd_en", {63'b0, bus.mem_read_enb}, 64'd0);
    check("rst_wr_en", {63'b0, bus.mem_write_enb}, 64'd0);
    rst_n = 1'b1;
    w0 = wr_cnt;
    rd_seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      rd_seen |= bus.mem_read_enb;
    end
    check("idle_no_reads", {63'b0, rd_seen}, 64'd0);
    check("idle_no_writes", 64'(wr_cnt - w0), 64'd0);

    // 1x1x1: 3 * -2
    ta[0][0] = 3; tbm[0][0] = -2;
    run_job(1, 1, 1, 1'b0, "t111");
    read_res(0, q);
    check("t111_lit", q, 64'hFFFF_FFFF_FFFF_FFFA);

    // 2x2x8: A ones, B^T rows 2 and -1
    for (int kk = 0; kk < 8; kk++) begin
      ta[0][kk] = 1; ta[1][kk] = 1; tbm[0][kk] = 2; tbm[1][kk] = -1;
    end
    run_job(2, 2, 8, 1'b0, "t228");
    read_res(0, q); check("t228_lit0", q, 64'd16);
    read_res(1, q); check("t228_lit1", q, 64'hFFFF_FFFF_FFFF_FFF8);
    read_res(2, q); check("t228_lit2", q, 64'd16);
    read_res(3, q); check("t228_lit3", q, 64'hFFFF_FFFF_FFFF_FFF8);

    // K=9, garbage in the padding lanes
    for (int i = 0; i < 3; i++)
      for (int kk = 0; kk < 9; kk++) begin
        ta[i][kk]  = ((i * 7 + kk * 3) % 17) - 8;
        tbm[i][kk] = ((i * 5 + kk * 11) % 23) - 11;
      end
    run_job(2, 3, 9, 1'b1, "tk9");

    // K=512 extremes
    for (int kk = 0; kk < 512; kk++) begin
      ta[0][kk] = -128; tbm[0][kk] = -128;
    end
    run_job(1, 1, 512, 1'b0, "tk512");
    read_res(0, q);
    check("tk512_lit", q, 64'd8388608);

    run_job(1, 1, 0, 1'b0, "tk0");
    run_job(129, 1, 4, 1'b0, "tm129");

    // comp_enb pulse during a run is ignored
    for (int i = 0; i < 3; i++)
      for (int kk = 0; kk < 20; kk++) begin
        ta[i][kk]  = ((i * 37 + kk * 13) % 256) - 128;
        tbm[i][kk] = ((i * 53 + kk * 7 + 5) % 256) - 128;
      end
    load_job(3, 3, 20, 1'b1);
    w0 = wr_cnt;
    start_job("tpulse");
    repeat (10) @(negedge clk);
    bus.comp_enb = 1'b1;
    @(negedge clk);
    bus.comp_enb = 1'b0;
    check("tpulse_still_busy", {63'b0, bus.busyb}, 64'd0);
    wait_done("tpulse");
    check("tpulse_writes", 64'(wr_cnt - w0), 64'd9);
    check("tpulse_queue_empty", 64'(exp_q.size()), 64'd0);

    // reset in the middle of a run
    load_job(3, 3, 20, 1'b0);
    w0 = wr_cnt;
    start_job("tabort");
    c = 0;
    while (wr_cnt < w0 + 2 && c < 20000) begin
      @(negedge clk);
      c++;
    end
    check("tabort_reached_writes", 64'(wr_cnt - w0), 64'd2);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("tabort_busyb", {63'b0, bus.busyb}, 64'd1);
    check("tabort_done", {63'b0, bus.done}, 64'd0);
    check("tabort_wr_en", {63'b0, bus.mem_write_enb}, 64'd0);
    check("tabort_rd_en", {63'b0, bus.mem_read_enb}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    w0 = wr_cnt;
    repeat (50) @(negedge clk);
    check("tabort_no_writes", 64'(wr_cnt - w0), 64'd0);

    // fresh run after abort recomputes
    run_job(3, 3, 20, 1'b0, "tafter");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
